// File: rtl/seven_segment_scan_driver_if.sv
// Bus bundle between a register-file/debug source and the seven-segment
// scan driver: staged display data plus load handshake on one side,
// board-level display pins and status pulses on the other.
`timescale 1ns/1ps

interface seven_segment_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    // Source side: data to display and its one-cycle load request
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    lz_suppress;

    // Display side: pin levels already at board polarity
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;

    // Status pulses
    logic                    load_ack;
    logic                    frame_done;

    // Data source (processor, register file, testbench)
    modport master (
        output value,
        output load,
        output dp_in,
        output digit_en,
        output lz_suppress,
        input  seg,
        input  dp,
        input  an,
        input  load_ack,
        input  frame_done
    );

    // Scan driver
    modport slave (
        input  value,
        input  load,
        input  dp_in,
        input  digit_en,
        input  lz_suppress,
        output seg,
        output dp,
        output an,
        output load_ack,
        output frame_done
    );
endinterface

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed hex seven-segment driver.
// One digit is selected per slot of CLK_DIV cycles; the first BLANK_CYCLES
// of each slot keep every anode off so the previous digit's pattern cannot
// ghost onto the next one. New data is staged on load and only copied into
// the display register at the frame wrap, so a frame never mixes old and
// new digits. All pins come straight from flops (one cycle behind the
// internal scan state) and carry the selected board polarity.
`timescale 1ns/1ps

module seven_segment_scan_driver #(
    parameter int NUM_DIGITS     = 4,      // 1..8, must match the interface
    parameter int CLK_DIV        = 50000,  // cycles per digit slot, >= 2
    parameter int BLANK_CYCLES   = 16,     // anode-off cycles at slot start
    parameter int SEG_ACTIVE_LOW = 1,      // 1: seg/dp low = lit
    parameter int AN_ACTIVE_LOW  = 1       // 1: an low = selected
) (
    input  logic                        clk,
    input  logic                        rst_n,
    seven_segment_scan_driver_if.slave  bus
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);

    // Pin levels that mean "unlit" / "not selected"; XOR with these maps
    // internal lit=1 encoding onto the board polarity.
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0)
                                                ? {NUM_DIGITS{1'b1}}
                                                : {NUM_DIGITS{1'b0}};

    // Hex nibble to segment pattern, bit order {g,f,e,d,c,b,a}, lit=1
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b0111111;
            4'h1:    pat = 7'b0000110;
            4'h2:    pat = 7'b1011011;
            4'h3:    pat = 7'b1001111;
            4'h4:    pat = 7'b1100110;
            4'h5:    pat = 7'b1101101;
            4'h6:    pat = 7'b1111101;
            4'h7:    pat = 7'b0000111;
            4'h8:    pat = 7'b1111111;
            4'h9:    pat = 7'b1101111;
            4'hA:    pat = 7'b1110111;
            4'hB:    pat = 7'b1111100;
            4'hC:    pat = 7'b0111001;
            4'hD:    pat = 7'b1011110;
            4'hE:    pat = 7'b1111001;
            4'hF:    pat = 7'b1110001;
            default: pat = 7'b0000000;
        endcase
        return pat;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]      div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [VAL_W-1:0]      stage_val_q, stage_val_d;
    logic [NUM_DIGITS-1:0] stage_dp_q,  stage_dp_d;
    logic [NUM_DIGITS-1:0] stage_en_q,  stage_en_d;
    logic                  pending_q,   pending_d;

    logic [VAL_W-1:0]      disp_val_q,  disp_val_d;
    logic [NUM_DIGITS-1:0] disp_dp_q,   disp_dp_d;
    logic [NUM_DIGITS-1:0] disp_en_q,   disp_en_d;

    logic                  load_ack_q,   load_ack_d;
    logic                  frame_done_q, frame_done_d;
    logic [6:0]            seg_q,        seg_d;
    logic                  dp_q,         dp_d;
    logic [NUM_DIGITS-1:0] an_q,         an_d;

    // Combinational helpers
    logic                  slot_end_s;
    logic                  wrap_s;
    logic                  zero_run_s;
    logic [NUM_DIGITS-1:0] supp_s;
    logic [NUM_DIGITS-1:0] sel_s;
    logic [3:0]            nib_s;
    logic                  en_sel_s;
    logic                  dp_sel_s;
    logic                  supp_sel_s;
    logic                  show_s;
    logic [6:0]            seg_int_s;
    logic                  dp_int_s;
    logic [NUM_DIGITS-1:0] an_int_s;

    // Slot divider and digit index; a frame wraps after the last digit's slot
    always_comb begin
        div_d      = div_q;
        idx_d      = idx_q;
        slot_end_s = (div_q == DIV_LAST);
        wrap_s     = slot_end_s && (idx_q == IDX_LAST);
        if (slot_end_s) begin
            div_d = {DIV_W{1'b0}};
            if (idx_q == IDX_LAST) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Staging capture, frame-aligned transfer to the display register, pulses.
    // A load on the wrap cycle itself refills staging while the previous
    // staging content is the one moved to the display, so pending stays set.
    always_comb begin
        stage_val_d  = stage_val_q;
        stage_dp_d   = stage_dp_q;
        stage_en_d   = stage_en_q;
        pending_d    = pending_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        disp_en_d    = disp_en_q;
        load_ack_d   = 1'b0;
        frame_done_d = wrap_s;

        if (bus.load) begin
            stage_val_d = bus.value;
            stage_dp_d  = bus.dp_in;
            stage_en_d  = bus.digit_en;
            pending_d   = 1'b1;
        end else if (wrap_s) begin
            pending_d   = 1'b0;
        end else begin
            pending_d   = pending_q;
        end

        if (wrap_s && pending_q) begin
            disp_val_d = stage_val_q;
            disp_dp_d  = stage_dp_q;
            disp_en_d  = stage_en_q;
            load_ack_d = 1'b1;
        end else begin
            load_ack_d = 1'b0;
        end
    end

    // Leading-zero mask: digit i is suppressed when it and every more
    // significant nibble are zero; digit 0 is never suppressed and dp bits
    // do not count as content.
    always_comb begin
        zero_run_s = 1'b1;
        supp_s     = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_s = zero_run_s & (disp_val_q[4*i +: 4] == 4'h0);
            supp_s[i]  = bus.lz_suppress & (i != 0) & zero_run_s;
        end
    end

    // Pick the selected digit and form the next pin levels
    always_comb begin
        sel_s      = {NUM_DIGITS{1'b0}};
        nib_s      = 4'h0;
        en_sel_s   = 1'b0;
        dp_sel_s   = 1'b0;
        supp_sel_s = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_s[i]   = (idx_q == IDX_W'(i));
            nib_s      = nib_s | ({4{sel_s[i]}} & disp_val_q[4*i +: 4]);
            en_sel_s   = en_sel_s   | (sel_s[i] & disp_en_q[i]);
            dp_sel_s   = dp_sel_s   | (sel_s[i] & disp_dp_q[i]);
            supp_sel_s = supp_sel_s | (sel_s[i] & supp_s[i]);
        end

        // Lit only outside the anti-ghost window and when enabled/unsuppressed
        show_s = (div_q >= BLANK_END) & en_sel_s & ~supp_sel_s;

        if (show_s) begin
            seg_int_s = hex_to_seg(nib_s);
            dp_int_s  = dp_sel_s;
            an_int_s  = sel_s;
        end else begin
            seg_int_s = 7'h00;
            dp_int_s  = 1'b0;
            an_int_s  = {NUM_DIGITS{1'b0}};
        end

        seg_d = seg_int_s ^ SEG_OFF;
        dp_d  = dp_int_s  ^ DP_OFF;
        an_d  = an_int_s  ^ AN_OFF;
    end

    // Scan counters, staging and display registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= {DIV_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            stage_val_q <= {VAL_W{1'b0}};
            stage_dp_q  <= {NUM_DIGITS{1'b0}};
            stage_en_q  <= {NUM_DIGITS{1'b0}};
            pending_q   <= 1'b0;
            disp_val_q  <= {VAL_W{1'b0}};
            disp_dp_q   <= {NUM_DIGITS{1'b0}};
            disp_en_q   <= {NUM_DIGITS{1'b0}};
        end else begin
            div_q       <= div_d;
            idx_q       <= idx_d;
            stage_val_q <= stage_val_d;
            stage_dp_q  <= stage_dp_d;
            stage_en_q  <= stage_en_d;
            pending_q   <= pending_d;
            disp_val_q  <= disp_val_d;
            disp_dp_q   <= disp_dp_d;
            disp_en_q   <= disp_en_d;
        end
    end

    // Output flops: pins at board polarity, inactive while in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.load_ack   = load_ack_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scoreboard bench for seven_segment_scan_driver (4 digits, 4-cycle slots,
// 1 blank cycle). Two instances share the same inputs: one with active-low
// pins, one with active-high pins. Stimulus pushes per-cycle expectations
// (lit=1 encoding) into a queue; a monitor pops one entry each cycle and
// checks both instances, inverting levels for the active-low one.
`timescale 1ns/1ps

module tb_seven_segment_scan_driver;

    localparam int ND = 4;

    logic clk;
    logic rst_n;
    int   k;        // rising edges since the last reset release
    int   total;
    int   bad;

    seven_segment_scan_driver_if #(.NUM_DIGITS(ND)) ifa ();
    seven_segment_scan_driver_if #(.NUM_DIGITS(ND)) ifb ();

    assign ifb.value       = ifa.value;
    assign ifb.load        = ifa.load;
    assign ifb.dp_in       = ifa.dp_in;
    assign ifb.digit_en    = ifa.digit_en;
    assign ifb.lz_suppress = ifa.lz_suppress;

    seven_segment_scan_driver #(
        .NUM_DIGITS(ND), .CLK_DIV(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut_lo (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
    );

    seven_segment_scan_driver #(
        .NUM_DIGITS(ND), .CLK_DIV(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
    ) dut_hi (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ack;
        logic       fd;
        string      name;
        int         slot;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Segment codes, lit=1, {g..a}
    localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S4 = 7'h66;
    localparam logic [6:0] S5 = 7'h6D, S6 = 7'h7D, S7 = 7'h07, S8 = 7'h7F;
    localparam logic [6:0] SA = 7'h77, SB = 7'h7C, SC = 7'h39, SD = 7'h5E;
    localparam logic [6:0] SF = 7'h71;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    // Monitor: one expectation per cycle while the queue holds entries
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            total++;
            if (ifa.an !== ~mon_e.an || ifa.seg !== ~mon_e.seg || ifa.dp !== ~mon_e.dp ||
                ifa.load_ack !== mon_e.ack || ifa.frame_done !== mon_e.fd) begin
                bad++;
                $display("FAIL %s[%0d] lowpol: got an=%h seg=%h dp=%b ack=%b fd=%b want an=%h seg=%h dp=%b ack=%b fd=%b",
                         mon_e.name, mon_e.slot, ifa.an, ifa.seg, ifa.dp, ifa.load_ack, ifa.frame_done,
                         ~mon_e.an, ~mon_e.seg, ~mon_e.dp, mon_e.ack, mon_e.fd);
            end
            total++;
            if (ifb.an !== mon_e.an || ifb.seg !== mon_e.seg || ifb.dp !== mon_e.dp ||
                ifb.load_ack !== mon_e.ack || ifb.frame_done !== mon_e.fd) begin
                bad++;
                $display("FAIL %s[%0d] highpol: got an=%h seg=%h dp=%b ack=%b fd=%b want an=%h seg=%h dp=%b ack=%b fd=%b",
                         mon_e.name, mon_e.slot, ifb.an, ifb.seg, ifb.dp, ifb.load_ack, ifb.frame_done,
                         mon_e.an, mon_e.seg, mon_e.dp, mon_e.ack, mon_e.fd);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dpv);
        ifa.value    = v;
        ifa.digit_en = en;
        ifa.dp_in    = dpv;
        ifa.load     = 1'b1;
        step(1);
        ifa.load     = 1'b0;
    endtask

    task automatic push_reset(input string name);
        exp_t e;
        e.an = 4'h0; e.seg = 7'h00; e.dp = 1'b0; e.ack = 1'b0; e.fd = 1'b0;
        e.name = name; e.slot = 0;
        exp_q.push_back(e);
    endtask

    // Called right after edge 16m+1: expectations for edges 16m+1..16m+16.
    // codes = {d3,d2,d1,d0}; lit = digits visible; dpm = dp lit per digit;
    // ack = transfer expected at this frame's closing wrap.
    task automatic push_frame(input logic [27:0] codes, input logic [3:0] lit,
                              input logic [3:0] dpm, input logic ack, input string name);
        exp_t e;
        int   d;
        int   i;
        logic act;
        for (int j = 0; j < 16; j++) begin
            d   = j % 4;
            i   = j / 4;
            act = (d >= 1) && lit[i];
            e.an   = act ? (4'b0001 << i) : 4'h0;
            e.seg  = act ? codes[7*i +: 7] : 7'h00;
            e.dp   = act & dpm[i];
            e.fd   = (j == 15);
            e.ack  = (j == 15) & ack;
            e.name = name;
            e.slot = j;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        k     = 0;
        rst_n = 1'b0;
        ifa.value       = 16'h0000;
        ifa.load        = 1'b0;
        ifa.dp_in       = 4'h0;
        ifa.digit_en    = 4'hF;
        ifa.lz_suppress = 1'b0;

        push_reset("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = 0;

        // Scan order/timing: display starts cleared (enables off) -> dark frame
        do_load(16'h12AF, 4'hF, 4'h0);
        push_frame({S0, S0, S0, S0}, 4'h0, 4'h0, 1'b1, "t1_pre");
        step(16);
        push_frame({S1, S2, SA, SF}, 4'hF, 4'h0, 1'b0, "t1_scan");
        step(16);

        // Tear-free load: 2222 loaded at idx=1 does not disturb digits 2,3
        push_frame({S1, S2, SA, SF}, 4'hF, 4'h0, 1'b1, "t2_prep");
        do_load(16'h1111, 4'hF, 4'h0);
        step(15);
        push_frame({S1, S1, S1, S1}, 4'hF, 4'h0, 1'b1, "t2_tear");
        step(4);
        do_load(16'h2222, 4'hF, 4'h0);
        step(11);

        // Leading-zero suppression
        push_frame({S2, S2, S2, S2}, 4'hF, 4'h0, 1'b1, "t2_new");
        ifa.lz_suppress = 1'b1;
        do_load(16'h0050, 4'hF, 4'h0);
        step(15);
        push_frame({S0, S0, S5, S0}, 4'b0011, 4'h0, 1'b1, "t3_lz");
        do_load(16'h0000, 4'hF, 4'h0);
        step(15);
        push_frame({S0, S0, S0, S0}, 4'b0001, 4'h0, 1'b0, "t3_zero");
        step(15);
        ifa.lz_suppress = 1'b0;
        step(1);

        // Enables and decimal points
        push_frame({S0, S0, S0, S0}, 4'hF, 4'h0, 1'b1, "t3_nolz");
        do_load(16'h4321, 4'b1010, 4'b0011);
        step(15);
        push_frame({S4, 7'h00, S2, 7'h00}, 4'b1010, 4'b0011, 1'b0, "t4_en_dp");
        step(16);

        // Load on the wrap cycle: old staging acked now, new data one frame later
        push_frame({S4, 7'h00, S2, 7'h00}, 4'b1010, 4'b0011, 1'b1, "t5_prior");
        do_load(16'hABCD, 4'hF, 4'h0);
        step(13);
        do_load(16'h5678, 4'hF, 4'h0);
        step(1);
        push_frame({SA, SB, SC, SD}, 4'hF, 4'h0, 1'b1, "t5_old");
        step(16);
        push_frame({S5, S6, S7, S8}, 4'hF, 4'h0, 1'b0, "t5_new");
        step(16);

        // Reset mid-slot with a pending load: pins drop at once, load is lost
        do_load(16'h9999, 4'hF, 4'h0);
        step(3);
        rst_n = 1'b0;
        push_reset("t5_rst_hold");
        push_reset("t5_rst_hold");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = 0;
        step(1);
        push_frame({S0, S0, S0, S0}, 4'h0, 4'h0, 1'b0, "t5_after_rst");
        step(16);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
